// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Shared types, widths and LED pattern helpers for the LED
//               bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SHIFT_L = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_COUNT   = 2'd3
    } mode_e;

    // First LED value shown after a mode is (re)started.
    function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
        logic [LED_W-1:0] v;
        case (m)
            MODE_OFF:     v = '0;
            MODE_SHIFT_L: v = {{(LED_W-1){1'b0}}, 1'b1};
            MODE_BLINK:   v = '1;
            default:      v = '0;
        endcase
        return v;
    endfunction

    // LED value one pattern step after cur.
    function automatic logic [LED_W-1:0] step_pattern(input mode_e m,
                                                      input logic [LED_W-1:0] cur);
        logic [LED_W-1:0] v;
        case (m)
            MODE_OFF:     v = '0;
            MODE_SHIFT_L: v = {cur[LED_W-2:0], cur[LED_W-1]};
            MODE_BLINK:   v = ~cur;
            default:      v = cur + {{(LED_W-1){1'b0}}, 1'b1};
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Enable-gated prescaler producing a registered one-cycle tick
//               every TICK_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int          CNT_W    = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Count enabled cycles; wrap and pulse tick on the last count of a period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_cnt == c_last) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + c_one;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_ctrl
// Description : 4-LED pattern controller. Mode requests arrive over a
//               valid/ready handshake and are applied only on a tick
//               boundary so the visible sequence never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             mode_valid,
    output logic             mode_ready,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic             tick
);

    logic             w_tick;
    logic             w_en;
    logic             w_accept;

    mode_e            r_cur_mode,     w_cur_mode_nxt;
    mode_e            r_pending_mode, w_pending_mode_nxt;
    logic             r_pending,      w_pending_nxt;
    logic [LED_W-1:0] r_led,          w_led_nxt;

    assign w_en = ~pause;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .tick  (w_tick)
    );

    // A new request is only taken while nothing is outstanding.
    assign w_accept = mode_valid && !r_pending;

    // Mode, pending request and LED state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_mode     <= MODE_SHIFT_L;
            r_pending_mode <= MODE_SHIFT_L;
            r_pending      <= 1'b0;
            r_led          <= init_pattern(MODE_SHIFT_L);
        end else begin
            r_cur_mode     <= w_cur_mode_nxt;
            r_pending_mode <= w_pending_mode_nxt;
            r_pending      <= w_pending_nxt;
            r_led          <= w_led_nxt;
        end
    end

    // On a tick either switch to the pending mode or advance the pattern;
    // a request accepted on a tick cycle is only seen by the next tick.
    always_comb begin
        w_cur_mode_nxt     = r_cur_mode;
        w_pending_mode_nxt = r_pending_mode;
        w_pending_nxt      = r_pending;
        w_led_nxt          = r_led;

        if (w_tick) begin
            if (r_pending) begin
                w_cur_mode_nxt = r_pending_mode;
                w_led_nxt      = init_pattern(r_pending_mode);
                w_pending_nxt  = 1'b0;
            end else begin
                w_led_nxt = step_pattern(r_cur_mode, r_led);
            end
        end

        if (w_accept) begin
            w_pending_mode_nxt = mode_e'(mode);
            w_pending_nxt      = 1'b1;
        end
    end

    assign mode_ready = ~r_pending;
    assign led        = r_led;
    assign tick       = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_mode_ctrl
// Description : Directed self-checking bench for led_mode_ctrl with a
//               scoreboard of expected LED values per pattern step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_ctrl;

    localparam int unsigned c_tick_div = 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [1:0] mode       = 2'd0;
    logic       mode_valid = 1'b0;
    logic       pause      = 1'b0;
    logic       mode_ready;
    logic [3:0] led;
    logic       tick;

    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         last_tick  = -1;
    logic [3:0] exp_q[$];

    led_mode_ctrl #(
        .TICK_DIV (c_tick_div),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .pause      (pause),
        .led        (led),
        .tick       (tick)
    );

    // 20 ns clock.
    always #10 clk = ~clk;

    // Free-running cycle counter for latency and period checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until tick is seen high, then check spacing to the previous tick.
    task automatic do_tick(input string tag);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (tick !== 1'b1) chk({tag, "_tick_timeout"}, 32'(tick), 1);
        if (last_tick >= 0) chk({tag, "_period"}, cyc - last_tick, c_tick_div);
        last_tick = cyc;
    endtask

    // The LED update lands one edge after tick; compare with the scoreboard head.
    task automatic finish_step(input string tag);
        logic [3:0] e;
        @(posedge clk); #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        chk({tag, "_led"}, 32'(led), 32'(e));
        chk({tag, "_tick_1cyc"}, 32'(tick), 0);
    endtask

    task automatic next_step(input string tag);
        do_tick(tag);
        finish_step(tag);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        int ticks_seen;
        int c0;

        // Reset held for 100 ns.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 4'b0001);
        chk("rst_ready", 32'(mode_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        rst_n = 1'b1;
        last_tick = cyc;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        repeat (4) next_step("shift");

        // Request BLINK.
        mode = 2'd2; mode_valid = 1'b1;
        @(posedge clk); #1;
        mode_valid = 1'b0;
        chk("blink_req_ready_low", 32'(mode_ready), 0);
        exp_q.push_back(4'b1111);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1111);
        do_tick("blink_apply");
        chk("blink_ready_at_tick", 32'(mode_ready), 0);
        finish_step("blink_apply");
        chk("blink_ready_back", 32'(mode_ready), 1);
        repeat (2) next_step("blink");

        // Back to SHIFT_L, then a COUNT request accepted on the tick cycle at led=0010.
        mode = 2'd1; mode_valid = 1'b1;
        @(posedge clk); #1;
        mode_valid = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        next_step("to_shift");
        next_step("to_shift");
        exp_q.push_back(4'b0100);
        do_tick("acc_on_tick");
        mode = 2'd3; mode_valid = 1'b1;
        finish_step("acc_on_tick_old");
        mode_valid = 1'b0;
        chk("acc_on_tick_ready", 32'(mode_ready), 0);
        exp_q.push_back(4'b0000);
        next_step("count_apply");

        // COUNT up to 0101, then pause 20 cycles.
        for (int v = 1; v <= 5; v++) exp_q.push_back(4'(v));
        repeat (5) next_step("count");
        pause = 1'b1;
        ticks_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tick) ticks_seen++;
        end
        chk("pause_led", 32'(led), 4'b0101);
        chk("pause_no_tick", ticks_seen, 0);
        pause = 1'b0;
        c0 = cyc;
        last_tick = -1;
        exp_q.push_back(4'b0110);
        next_step("unpause");
        chk("unpause_latency", cyc - c0, 4);
        for (int v = 7; v <= 15; v++) exp_q.push_back(4'(v));
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0001);
        repeat (11) next_step("count_wrap");

        // OFF request aborted by reset before it can apply.
        mode = 2'd0; mode_valid = 1'b1;
        @(posedge clk); #1;
        mode_valid = 1'b0;
        chk("off_req_ready_low", 32'(mode_ready), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_led", 32'(led), 4'b0001);
        chk("midrst_ready", 32'(mode_ready), 1);
        chk("midrst_tick", 32'(tick), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_tick = cyc;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        next_step("post_rst_shift");
        next_step("post_rst_shift");

        // Back-pressure: COUNT held valid across an entire outstanding request.
        mode = 2'd3; mode_valid = 1'b1;
        accepts = 0;
        exp_q.push_back(4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (mode_ready) accepts++;
            @(posedge clk); #1;
        end
        last_tick = cyc - 1;
        chk("bp_one_accept", accepts, 1);
        chk("bp_apply_led", 32'(led), 32'(exp_q.pop_front()));
        chk("bp_ready_back", 32'(mode_ready), 1);
        if (mode_ready) accepts++;
        @(posedge clk); #1;
        mode_valid = 1'b0;
        chk("bp_reaccept", accepts, 2);
        chk("bp_ready_low", 32'(mode_ready), 0);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0001);
        next_step("bp_restart");
        next_step("bp_count");

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Run-time controller for the 4-LED bank of the 50 MHz board. It owns a tick prescaler and a small mode state machine, and drives `led[3:0]` with one of four patterns. A requester (key handler or UART command decoder) switches patterns through a valid/ready handshake. A pattern switch takes effect only on a tick boundary, so the visible LED sequence never glitches.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per pattern step (1 s at 50 MHz); legal range 2..2^32-1.
- CNT_W, 32, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active-low; sampled on the rising edge of clk
- mode  in  2  requested mode: 0 OFF, 1 SHIFT_L, 2 BLINK, 3 COUNT
- mode_valid  in  1  mode request valid
- mode_ready  out  1  controller can accept a request
- pause  in  1  level; freezes the prescaler and the pattern
- led  out  4  LED drive, 1 = on, registered output
- tick  out  1  one-cycle pulse on each pattern step (for debug and chaining)

Behaviour:
- One clock domain. Reset is synchronous and active-low: clk with rst_n, where rst_n is sampled on the rising clk edge.
- Reset values:
  - cur_mode = SHIFT_L, led = 4'b0001, prescaler cnt = 0, tick = 0
  - pending flag = 0, mode_ready = 1
- Reset asserted mid-operation:
  - Aborts any pending request; the request is lost and is not replayed.
  - All state returns to the reset values on the next edge.
- Prescaler:
  - If pause = 0: cnt increments each cycle. When cnt == TICK_DIV-1, cnt wraps to 0 and tick = 1 in that same cycle (tick is registered, high for exactly 1 cycle).
  - If pause = 1: cnt holds and tick = 0.
  - First tick after reset release: TICK_DIV cycles later.
- Handshake:
  - A request is accepted on a cycle with mode_valid && mode_ready. The controller latches pending_mode, sets pending, and drives mode_ready = 0 from the next cycle.
  - mode_valid while mode_ready = 0 is ignored; the requester must hold it.
  - Only one request may be outstanding.
- Mode application:
  - On the first tick cycle strictly after the accept cycle: cur_mode <= pending_mode, led <= the initial value of that mode, and pending is cleared. mode_ready returns to 1 on the following cycle.
  - Accept and tick in the same cycle: that tick advances the old pattern normally. The new mode applies at the next tick.
  - A request for a mode equal to cur_mode still restarts that mode's pattern from its initial value.
  - pause = 1 delays application, since no tick occurs; requests are still accepted.
- Pattern step per tick (no pending switch), with initial values:
  - OFF: initial 0000; led stays 0000.
  - SHIFT_L: initial 0001; rotate left, so 1000 -> 0001 wraps.
  - BLINK: initial 1111; led <= ~led each tick.
  - COUNT: initial 0000; led <= led + 1 mod 16, so 1111 -> 0000 wraps.
- Between ticks, led holds its value.
- Latency: led changes exactly 1 cycle after the edge that sampled the tick condition, which is the same edge that asserts tick.

Decomposition:
- Package led_ctrl_pkg:
  - Mode encoding constants MODE_OFF = 0, MODE_SHIFT_L = 1, MODE_BLINK = 2, MODE_COUNT = 3
  - LED_W = 4
  - Function init_pattern(mode) returning the initial LED value
- Sub-module tick_gen:
  - Parameters: TICK_DIV, CNT_W
  - Ports: clk, rst_n, en (= ~pause), tick
  - Also reused later by the key debouncer.
- led_mode_ctrl contains the handshake register, the mode FSM and the LED register.

Test Plan:
All scenarios use TICK_DIV = 4 and a 20 ns clock.
- Reset: hold rst_n = 0 for 100 ns, then release -> led = 0001 and mode_ready = 1. Over the following ticks led is 0010, 0100, 1000, 0001, with one step every 4 cycles and tick high 1 cycle per step.
- Mode request: pulse mode = 2 with mode_valid = 1 while mode_ready = 1 -> mode_ready goes to 0. At the next tick led = 1111, then 0000, then 1111. mode_ready returns to 1 one cycle after the switch.
- Accept on a tick cycle: assert the request in the same cycle tick = 1, with cur_mode = SHIFT_L and led = 0010 -> that tick gives led = 0100. At the next tick the new mode's initial value is loaded.
- Pause: cur_mode = COUNT at led = 0101, pause = 1 for 20 cycles -> led stays 0101 and tick stays 0. After pause = 0, the next step gives 0110 after 4 cycles. Separately, 1111 -> 0000 wraps.
- Reset mid-request: accept mode = 0, then drive rst_n = 0 before the next tick -> the following cycle shows led = 0001 and mode_ready = 1. After release the mode remains SHIFT_L and the OFF request is never applied.
- Back-pressure: hold mode_valid = 1 with mode = 3 while mode_ready = 0 -> only one accept occurs. After mode_ready rises, the request is accepted once more, which restarts COUNT at 0000.
